// File: rtl/uart_tx_core.sv
// UART transmitter: FIFO-buffered, 16x oversample tick, LSB-first framing.
// Optional parity bit enabled by defining UART_TX_PARITY_EN.
`default_nettype none

module uart_tx_core #(
    parameter int DBIT       = 8,
    parameter int SB_TICK    = 16,
    parameter int DIV        = 326,
    parameter int FIFO_W     = 2,
    parameter int PARITY_ODD = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wr,
    input  logic [DBIT-1:0] w_data,
    output logic            full,
    output logic            empty,
    output logic            overflow,
    output logic            tx_busy,
    output logic            tx_done_tick,
    output logic            tx
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int S_MAX = (SB_TICK > 16) ? SB_TICK : 16;
    localparam int S_W   = $clog2(S_MAX);
    localparam int N_W   = (DBIT > 1) ? $clog2(DBIT) : 1;
    localparam int DEPTH = 1 << FIFO_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_TX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [CNT_W-1:0]  r_tick_cnt;
    logic              w_tick;
    logic [S_W-1:0]    r_s_cnt;
    logic [S_W-1:0]    w_s_next;
    logic [N_W-1:0]    r_n_cnt;
    logic [N_W-1:0]    w_n_next;
    logic [DBIT-1:0]   r_shift;
    logic [DBIT-1:0]   w_shift_next;
    logic              r_tx;
    logic              w_tx_next;
    logic              w_done;

    logic [DBIT-1:0]   r_mem [DEPTH];
    logic [FIFO_W-1:0] r_wptr;
    logic [FIFO_W-1:0] r_rptr;
    logic [FIFO_W-1:0] w_wptr_succ;
    logic [FIFO_W-1:0] w_rptr_succ;
    logic              r_full;
    logic              r_empty;
    logic              r_overflow;
    logic              w_pop;
    logic              w_push;

    // A push while full is still accepted when the transmitter pops in the same cycle.
    assign w_pop       = (r_state == ST_IDLE) && !r_empty;
    assign w_push      = wr && (!r_full || w_pop);
    assign w_wptr_succ = r_wptr + FIFO_W'(1);
    assign w_rptr_succ = r_rptr + FIFO_W'(1);

    // NOTE: storage carries no reset; pointers and flags alone define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wptr <= w_wptr_succ;
            if (w_pop)  r_rptr <= w_rptr_succ;
            if (wr && !w_push) r_overflow <= 1'b1;
            if (w_push && !w_pop) begin
                r_empty <= 1'b0;
                r_full  <= (w_wptr_succ == r_rptr);
            end else if (w_pop && !w_push) begin
                r_full  <= 1'b0;
                r_empty <= (w_rptr_succ == r_wptr);
            end
        end
    end

    assign w_tick = (r_tick_cnt == CNT_W'(DIV - 1));

    always_ff @(posedge clk) begin
        if (reset || r_state == ST_IDLE || w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + CNT_W'(1);
        end
    end

`ifdef UART_TX_PARITY_EN
    localparam logic PAR_INV = (PARITY_ODD != 0);
    logic r_parity;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_parity <= 1'b0;
        end else if (w_pop) begin
            r_parity <= (^r_mem[r_rptr]) ^ PAR_INV;
        end
    end
`else
    // Parity sense has no meaning without a parity bit.
    logic w_unused_parity_odd;
    assign w_unused_parity_odd = (PARITY_ODD != 0);
`endif

    // NOTE: every output of this block gets a default first, so no latches are inferred.
    always_comb begin
        w_state_next = r_state;
        w_s_next     = r_s_cnt;
        w_n_next     = r_n_cnt;
        w_shift_next = r_shift;
        w_done       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_s_next = '0;
                w_n_next = '0;
                if (!r_empty) begin
                    w_state_next = ST_START;
                    w_shift_next = r_mem[r_rptr];
                end
            end
            ST_START: begin
                if (w_tick) begin
                    if (r_s_cnt == S_W'(15)) begin
                        w_s_next     = '0;
                        w_state_next = ST_DATA;
                    end else begin
                        w_s_next = r_s_cnt + S_W'(1);
                    end
                end
            end
            ST_DATA: begin
                if (w_tick) begin
                    if (r_s_cnt == S_W'(15)) begin
                        w_s_next     = '0;
                        w_shift_next = r_shift >> 1;
                        if (r_n_cnt == N_W'(DBIT - 1)) begin
`ifdef UART_TX_PARITY_EN
                            w_state_next = ST_PARITY;
`else
                            w_state_next = ST_STOP;
`endif
                        end else begin
                            w_n_next = r_n_cnt + N_W'(1);
                        end
                    end else begin
                        w_s_next = r_s_cnt + S_W'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (w_tick) begin
                    if (r_s_cnt == S_W'(15)) begin
                        w_s_next     = '0;
                        w_state_next = ST_STOP;
                    end else begin
                        w_s_next = r_s_cnt + S_W'(1);
                    end
                end
            end
`endif
            ST_STOP: begin
                if (w_tick) begin
                    if (r_s_cnt == S_W'(SB_TICK - 1)) begin
                        w_done       = 1'b1;
                        w_state_next = ST_IDLE;
                    end else begin
                        w_s_next = r_s_cnt + S_W'(1);
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Line level is registered from the next state so tx changes with the state register.
    always_comb begin
        w_tx_next = 1'b1;
        case (w_state_next)
            ST_START:  w_tx_next = 1'b0;
            ST_DATA:   w_tx_next = w_shift_next[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: w_tx_next = r_parity;
`endif
            default:   w_tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_s_cnt <= '0;
            r_n_cnt <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_s_cnt <= w_s_next;
            r_n_cnt <= w_n_next;
            r_shift <= w_shift_next;
            r_tx    <= w_tx_next;
        end
    end

    assign tx           = r_tx;
    assign tx_busy      = (r_state != ST_IDLE);
    assign tx_done_tick = w_done;
    assign full         = r_full;
    assign empty        = r_empty;
    assign overflow     = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_core.sv
// Directed bench for uart_tx_core at DIV=4: instance A uses a 1-bit stop and even parity,
// instance B a 2-bit stop and odd parity. Expected waveforms are built from the bytes sent.
module tb_uart_tx_core;

    localparam int BIT_CYC = 64;
`ifdef UART_TX_PARITY_EN
    localparam int HAS_PAR = 1;
`else
    localparam int HAS_PAR = 0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_a, wr_b;
    logic [7:0] wd_a, wd_b;
    logic       full_a, empty_a, ovf_a, busy_a, done_a, tx_a;
    logic       full_b, empty_b, ovf_b, busy_b, done_b, tx_b;
    logic       sel_b;
    logic       mon_tx, mon_done, mon_busy, mon_empty;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    uart_tx_core #(.DBIT(8), .SB_TICK(16), .DIV(4), .FIFO_W(2), .PARITY_ODD(0)) u_dut_a (
        .clk(clk), .reset(reset), .wr(wr_a), .w_data(wd_a),
        .full(full_a), .empty(empty_a), .overflow(ovf_a),
        .tx_busy(busy_a), .tx_done_tick(done_a), .tx(tx_a)
    );

    uart_tx_core #(.DBIT(8), .SB_TICK(32), .DIV(4), .FIFO_W(2), .PARITY_ODD(1)) u_dut_b (
        .clk(clk), .reset(reset), .wr(wr_b), .w_data(wd_b),
        .full(full_b), .empty(empty_b), .overflow(ovf_b),
        .tx_busy(busy_b), .tx_done_tick(done_b), .tx(tx_b)
    );

    assign mon_tx    = sel_b ? tx_b    : tx_a;
    assign mon_done  = sel_b ? done_b  : done_a;
    assign mon_busy  = sel_b ? busy_b  : busy_a;
    assign mon_empty = sel_b ? empty_b : empty_a;

    task automatic write_byte(input logic [7:0] d);
        if (sel_b) begin wr_b = 1'b1; wd_b = d; end
        else       begin wr_a = 1'b1; wd_a = d; end
        @(negedge clk);
        wr_a = 1'b0;
        wr_b = 1'b0;
        wd_a = ~d;
        wd_b = ~d;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        wr_a  = 1'b0;
        wr_b  = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Waits for a start bit, compares every cycle of the frame, then steps one cycle past done.
    task automatic recv_frame(input logic [7:0] d, input logic par_odd, input int sb_cyc,
                              input string tag, output int wait_n, output logic empty_fall);
        int   cnt, len, bad, first_bad, idx;
        logic exp_bit, first_act;
        len    = (9 + HAS_PAR) * BIT_CYC + sb_cyc;
        wait_n = 0;
        while (mon_tx !== 1'b0 && wait_n < 3000) begin
            @(negedge clk);
            wait_n++;
        end
        empty_fall = mon_empty;
        if (mon_tx !== 1'b0) begin
            $display("FAIL %s start: tx=%b after %0d cycles, required 0", tag, mon_tx, wait_n);
            n_checks++;
            return;
        end
        cnt = 1; bad = 0; first_bad = 0; first_act = 1'b0;
        forever begin
            idx = (cnt - 1) / BIT_CYC;
            if (idx == 0)                        exp_bit = 1'b0;
            else if (idx <= 8)                   exp_bit = d[idx-1];
            else if (HAS_PAR != 0 && idx == 9)   exp_bit = (^d) ^ par_odd;
            else                                 exp_bit = 1'b1;
            if (mon_tx !== exp_bit) begin
                if (bad == 0) begin first_bad = cnt; first_act = mon_tx; end
                bad++;
            end
            if (mon_done === 1'b1 || cnt >= len + BIT_CYC) break;
            @(negedge clk);
            cnt++;
        end
        n_checks++;
        if (bad != 0)
            $display("FAIL %s waveform: %0d bad cycles, first at %0d tx=%b required %b",
                     tag, bad, first_bad, first_act, ~first_act);
        else n_pass++;
        n_checks++;
        if (cnt != len) $display("FAIL %s done_pos: got cycle %0d required %0d", tag, cnt, len);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({mon_done, mon_busy, mon_tx} !== 3'b001)
            $display("FAIL %s idle_after: done,busy,tx=%b required 001",
                     tag, {mon_done, mon_busy, mon_tx});
        else n_pass++;
    endtask

    task automatic expect_silence(input int cycles, input string tag);
        int lows = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (mon_tx !== 1'b1) lows++;
        end
        n_checks++;
        if (lows != 0) $display("FAIL %s: tx not idle for %0d cycles, required 0", tag, lows);
        else n_pass++;
    endtask

    task automatic test_reset();
        reset = 1'b1; wr_a = 1'b0; wr_b = 1'b0; wd_a = '0; wd_b = '0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({tx_a, busy_a, done_a, empty_a, full_a, ovf_a} !== 6'b100100)
            $display("FAIL reset_a: tx,busy,done,empty,full,ovf=%b required 100100",
                     {tx_a, busy_a, done_a, empty_a, full_a, ovf_a});
        else n_pass++;
        n_checks++;
        if ({tx_b, busy_b, done_b, empty_b, full_b, ovf_b} !== 6'b100100)
            $display("FAIL reset_b: tx,busy,done,empty,full,ovf=%b required 100100",
                     {tx_b, busy_b, done_b, empty_b, full_b, ovf_b});
        else n_pass++;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({tx_a, busy_a, empty_a} !== 3'b101)
            $display("FAIL idle_after_reset: tx,busy,empty=%b required 101", {tx_a, busy_a, empty_a});
        else n_pass++;
    endtask

    task automatic test_single_frame();
        int w; logic e;
        sel_b = 1'b0;
        write_byte(8'h55);
        recv_frame(8'h55, 1'b0, 64, "single_55", w, e);
        n_checks++;
        if (e !== 1'b1) $display("FAIL single_empty: got %b required 1", e);
        else n_pass++;
    endtask

    task automatic test_data_hold();
        int w; logic e;
        sel_b = 1'b0;
        write_byte(8'h3C);
        fork
            recv_frame(8'h3C, 1'b0, 64, "hold_3c", w, e);
            begin
                repeat (150) @(negedge clk);
                write_byte(8'h9A);
            end
        join
        recv_frame(8'h9A, 1'b0, 64, "mid_write_9a", w, e);
        n_checks++;
        if (w != 1) $display("FAIL mid_write_gap: got %0d idle cycles required 1", w);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int w1, w2, w3; logic e1, e2, e3;
        sel_b = 1'b0;
        fork
            begin write_byte(8'h01); write_byte(8'h02); write_byte(8'h03); end
            begin
                recv_frame(8'h01, 1'b0, 64, "b2b_01", w1, e1);
                recv_frame(8'h02, 1'b0, 64, "b2b_02", w2, e2);
                recv_frame(8'h03, 1'b0, 64, "b2b_03", w3, e3);
            end
        join
        n_checks++;
        if ({e1, e2, e3} !== 3'b001) $display("FAIL b2b_empty: got %b required 001", {e1, e2, e3});
        else n_pass++;
        n_checks++;
        if (w2 != 1 || w3 != 1) $display("FAIL b2b_gap: got %0d,%0d required 1,1", w2, w3);
        else n_pass++;
        expect_silence(300, "b2b_no_extra");
    endtask

    task automatic test_overflow();
        logic [7:0] bytes [6];
        int w; logic e;
        bytes = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6};
        sel_b = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++) write_byte(bytes[i]);
                n_checks++;
                if ({full_a, ovf_a} !== 2'b11)
                    $display("FAIL ovf_flags: full,ovf=%b required 11", {full_a, ovf_a});
                else n_pass++;
            end
            begin
                for (int i = 0; i < 5; i++) recv_frame(bytes[i], 1'b0, 64, "ovf_frame", w, e);
            end
        join
        expect_silence(800, "ovf_dropped");
        n_checks++;
        if ({ovf_a, empty_a, full_a} !== 3'b110)
            $display("FAIL ovf_sticky: ovf,empty,full=%b required 110", {ovf_a, empty_a, full_a});
        else n_pass++;
    endtask

    task automatic test_full_pop_write();
        logic [7:0] bytes [6];
        int w; logic e;
        bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        sel_b = 1'b0;
        do_reset();
        fork
            for (int i = 0; i < 5; i++) write_byte(bytes[i]);
            recv_frame(bytes[0], 1'b0, 64, "fpw_11", w, e);
        join
        n_checks++;
        if (full_a !== 1'b1) $display("FAIL fpw_full_idle: got %b required 1", full_a);
        else n_pass++;
        write_byte(bytes[5]);
        n_checks++;
        if ({full_a, ovf_a} !== 2'b10)
            $display("FAIL fpw_flags: full,ovf=%b required 10", {full_a, ovf_a});
        else n_pass++;
        for (int i = 1; i < 6; i++) recv_frame(bytes[i], 1'b0, 64, "fpw_frame", w, e);
        n_checks++;
        if (empty_a !== 1'b1) $display("FAIL fpw_drained: empty=%b required 1", empty_a);
        else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        int wait_n = 0;
        sel_b = 1'b0;
        write_byte(8'h00);
        while (tx_a !== 1'b0 && wait_n < 100) begin @(negedge clk); wait_n++; end
        repeat (199) @(negedge clk);
        n_checks++;
        if (tx_a !== 1'b0) $display("FAIL abort_pre: tx=%b required 0", tx_a);
        else n_pass++;
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({tx_a, busy_a, done_a, empty_a, full_a, ovf_a} !== 6'b100100)
            $display("FAIL abort_state: tx,busy,done,empty,full,ovf=%b required 100100",
                     {tx_a, busy_a, done_a, empty_a, full_a, ovf_a});
        else n_pass++;
        reset = 1'b0;
        expect_silence(1000, "abort_no_resend");
    endtask

    task automatic test_stop_len();
        int w; logic e;
        sel_b = 1'b1;
        write_byte(8'h55);
        recv_frame(8'h55, 1'b1, 128, "stop32_55", w, e);
        sel_b = 1'b0;
    endtask

    initial begin
        sel_b = 1'b0;
        test_reset();
        test_single_frame();
        test_data_hold();
        test_back_to_back();
        test_overflow();
        test_full_pop_write();
        test_reset_mid_frame();
        test_stop_len();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation ran past its time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
